pipelined_ks_subtractor: RTL and testbench
==========================================

PIPELINED_KS_SUBTRACTOR -- requirements
Module: pipelined_ks_subtractor

Interface
REQ-001 SHALL have parameter N, default 32, meaning word width; only 32 is supported and elaboration SHALL fail for any other value.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand set present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands this cycle.
REQ-006 SHALL have port A, input, [N:1], minuend.
REQ-007 SHALL have port B, input, [N:1], subtrahend.
REQ-008 SHALL have port Bin, input, 1, borrow in.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-011 SHALL have port D, output, [N:1], difference.
REQ-012 SHALL have port Bout, output, 1, borrow out.

Function
REQ-013 SHALL compute D = (A - B - Bin) mod 2^32, implemented as A + ~B + ~Bin on Kogge-Stone prefix logic.
REQ-014 SHALL drive Bout = 1 exactly when unsigned A < B + Bin, i.e. the inverted carry out of bit 32.
REQ-015 SHALL accept an operand set on any rising edge where in_valid && in_ready.
REQ-016 Stage 1 SHALL compute D[16:1] and the carry into bit 17, and register them with A[32:17], ~B[32:17] and s1_valid.
REQ-017 Stage 2 SHALL compute D[32:17] and Bout from the registered carry and register them with s2_valid.
REQ-018 out_valid SHALL equal s2_valid, and D and Bout SHALL be driven directly from stage-2 registers.
REQ-019 Latency SHALL be 2 cycles: an operand set accepted at edge k is first presented at edge k+2 when not stalled.
REQ-020 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-021 Stage 2 SHALL load when !s2_valid || out_ready.
REQ-022 in_ready SHALL equal !s1_valid || (!s2_valid || out_ready), with no combinational path from in_valid.
REQ-023 While out_valid && !out_ready, D, Bout and V SHALL remain stable.
REQ-024 At most 2 operand sets SHALL be in flight; with both stages full and out_ready = 0, in_ready SHALL be 0.
REQ-025 On simultaneous accept and drain, no result SHALL be lost or duplicated, and results SHALL leave in acceptance order.

Reset
REQ-026 When rst_n = 0, s1_valid, s2_valid, out_valid, D, Bout and V SHALL be 0 immediately, independent of clk.
REQ-027 Reset mid-operation SHALL discard all in-flight results.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 With macro KS_SUB_OVERFLOW_EN defined, the block SHALL add output port V, 1 bit, registered in stage 2, aligned with D.
REQ-030 V SHALL be 1 when the two's-complement result overflows: A[32] != B[32] && D[32] != A[32].
REQ-031 Without KS_SUB_OVERFLOW_EN, port V and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package ks_pkg SHALL hold: constants KS_N = 32 and KS_HALF = 16, typedef word_t (logic [32:1]) and typedef half_t (logic [16:1]).
REQ-033 Sub-module ks_prefix16 SHALL implement one 16-bit Kogge-Stone carry network (black and gray cells, carry-in, 4 prefix levels); it SHALL be instantiated twice, once per stage.

Verification
REQ-034 A = 0, B = 0, Bin = 0 -> D = 0x00000000, Bout = 0, out_valid at the 2nd edge after accept.
REQ-035 A = 0x00000000, B = 0x00000001, Bin = 0 -> D = 0xFFFFFFFF, Bout = 1; with Bin = 1 -> D = 0xFFFFFFFE, Bout = 1.
REQ-036 A = 0x00010000, B = 0x00000001 -> D = 0x0000FFFF, Bout = 0, proving the borrow crosses the stage boundary.
REQ-037 With KS_SUB_OVERFLOW_EN: A = 0x80000000, B = 1 -> D = 0x7FFFFFFF, V = 1, Bout = 0; A = 5, B = 3 -> V = 0.
REQ-038 Stream 4 back-to-back sets with out_ready = 0 for 3 cycles -> in_ready = 0 after 2 accepts, D held stable, then all 4 results in order once out_ready = 1.
REQ-039 Assert rst_n = 0 with 2 sets in flight -> out_valid = 0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared widths and word types for the pipelined Kogge-Stone subtractor.
package ks_pkg;

    localparam int KS_N    = 32;
    localparam int KS_HALF = 16;

    typedef logic [KS_N:1]    word_t;
    typedef logic [KS_HALF:1] half_t;

endpackage

// File: rtl/ks_prefix16.sv
// 16-bit Kogge-Stone adder slice with carry-in: four prefix levels of
// black cells (group generate + propagate) and gray cells (generate only,
// used once a position's carry is complete back to the carry-in).
module ks_prefix16
    import ks_pkg::*;
(
    input  half_t a,
    input  half_t b,
    input  logic  cin,
    output half_t sum,
    output logic  cout
);

    localparam int LEVELS = 4;

    half_t p_raw;
    half_t g_acc;
    half_t p_acc;
    half_t g_nxt;
    half_t p_nxt;
    half_t carry;

    // Prefix network; carry-in is folded into bit 1 so four levels span all 16 bits
    always_comb begin
        p_raw    = a ^ b;
        g_acc    = a & b;
        g_acc[1] = g_acc[1] | (p_raw[1] & cin);
        p_acc    = p_raw;
        for (int l = 0; l < LEVELS; l++) begin
            g_nxt = g_acc;
            p_nxt = '0;
            for (int i = 1; i <= KS_HALF; i++) begin
                if (i > (2 << l)) begin
                    g_nxt[i] = g_acc[i] | (p_acc[i] & g_acc[i - (1 << l)]);
                    p_nxt[i] = p_acc[i] & p_acc[i - (1 << l)];
                end else if (i > (1 << l)) begin
                    g_nxt[i] = g_acc[i] | (p_acc[i] & g_acc[i - (1 << l)]);
                end
            end
            g_acc = g_nxt;
            p_acc = p_nxt;
        end
        carry = {g_acc[KS_HALF-1:1], cin};
        sum   = p_raw ^ carry;
        cout  = g_acc[KS_HALF];
    end

endmodule

// File: rtl/pipelined_ks_subtractor.sv
// Two-stage pipelined 32-bit subtractor D = A - B - Bin built as A + ~B + ~Bin.
// Stage 1 resolves the low half and the carry into bit 17; stage 2 the high half.
// Optional macro KS_SUB_OVERFLOW_EN adds the registered two's-complement overflow
// output V.
module pipelined_ks_subtractor
    import ks_pkg::*;
#(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [N:1] A,
    input  logic [N:1] B,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [N:1] D,
    output logic       Bout
`ifdef KS_SUB_OVERFLOW_EN
    ,
    output logic       V
`endif
);

    if (N != KS_N) begin : g_bad_width
        $error("pipelined_ks_subtractor supports only N = 32");
    end

    half_t lo_sum;
    logic  lo_cout;
    half_t hi_sum;
    logic  hi_cout;
    half_t b_lo_n;
    logic  s2_load;

    half_t d_lo_d, d_lo_q;
    half_t a_hi_d, a_hi_q;
    half_t nb_hi_d, nb_hi_q;
    logic  c17_d, c17_q;
    logic  s1_valid_d, s1_valid_q;
    word_t d_d, d_q;
    logic  bout_d, bout_q;
    logic  s2_valid_d, s2_valid_q;
`ifdef KS_SUB_OVERFLOW_EN
    logic  v_d, v_q;
`endif

    assign b_lo_n = ~B[KS_HALF:1];

    ks_prefix16 u_prefix_lo (
        .a    (A[KS_HALF:1]),
        .b    (b_lo_n),
        .cin  (~Bin),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    ks_prefix16 u_prefix_hi (
        .a    (a_hi_q),
        .b    (nb_hi_q),
        .cin  (c17_q),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // Handshake and next-state for both stages; stages hold unless they load
    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_load;

        s1_valid_d = s1_valid_q;
        d_lo_d     = d_lo_q;
        a_hi_d     = a_hi_q;
        nb_hi_d    = nb_hi_q;
        c17_d      = c17_q;
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bout_d     = bout_q;
`ifdef KS_SUB_OVERFLOW_EN
        v_d        = v_q;
`endif

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                d_lo_d  = lo_sum;
                c17_d   = lo_cout;
                a_hi_d  = A[N:KS_HALF+1];
                nb_hi_d = ~B[N:KS_HALF+1];
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d    = {hi_sum, d_lo_q};
                bout_d = ~hi_cout;
`ifdef KS_SUB_OVERFLOW_EN
                // Operand signs differ and the result sign disagrees with A
                v_d    = (a_hi_q[KS_HALF] == nb_hi_q[KS_HALF]) &&
                         (hi_sum[KS_HALF] != a_hi_q[KS_HALF]);
`endif
            end
        end
    end

    // Pipeline registers; reset empties both stages and clears the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            d_lo_q     <= '0;
            a_hi_q     <= '0;
            nb_hi_q    <= '0;
            c17_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
`ifdef KS_SUB_OVERFLOW_EN
            v_q        <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            d_lo_q     <= d_lo_d;
            a_hi_q     <= a_hi_d;
            nb_hi_q    <= nb_hi_d;
            c17_q      <= c17_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
`ifdef KS_SUB_OVERFLOW_EN
            v_q        <= v_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;
`ifdef KS_SUB_OVERFLOW_EN
    assign V         = v_q;
`endif

endmodule

// File: tb/tb_pipelined_ks_subtractor.sv
// Self-checking bench for pipelined_ks_subtractor; build with KS_SUB_OVERFLOW_EN
// defined to also check V.
module tb_pipelined_ks_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:1] A = '0;
    logic [32:1] B = '0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:1] D;
    logic        Bout;
`ifdef KS_SUB_OVERFLOW_EN
    logic        V;
`endif

    int total = 0;
    int bad = 0;
    bit rand_ready = 1'b0;

    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        v;
    } exp_t;

    exp_t sb[$];

    pipelined_ks_subtractor #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef KS_SUB_OVERFLOW_EN
        ,
        .V         (V)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b} - {32'b0, bin};
        e.d    = r[31:0];
        e.bout = r[32];
        e.v    = (a[31] != b[31]) && (r[31] != a[31]);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on each delivered result
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: unexpected result D=%h Bout=%b, required no result", D, Bout);
                end else begin
                    e = sb.pop_front();
                    if (D !== e.d || Bout !== e.bout) begin
                        bad++;
                        $display("FAIL sb_result: D=%h Bout=%b, required D=%h Bout=%b", D, Bout, e.d, e.bout);
                    end
`ifdef KS_SUB_OVERFLOW_EN
                    total++;
                    if (V !== e.v) begin
                        bad++;
                        $display("FAIL sb_v: V=%b, required %b (D=%h)", V, e.v, e.d);
                    end
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(model(A, B, Bin));
        end
    end

    // Present one operand set and hold it until accepted; leaves in_valid high
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
        int  n = 0;
        logic took = 1'b0;
        A = a;
        B = b;
        Bin = bin;
        in_valid = 1'b1;
        while (!took && n < 50) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!took) begin
            bad++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic drain();
        int  n = 0;
        logic idle = 1'b0;
        in_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        while (!idle && n < 20) begin
            @(negedge clk);
            idle = !out_valid && (sb.size() == 0);
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (out_valid !== 1'b0 || D !== 32'h0 || Bout !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: out_valid=%b D=%h Bout=%b, required 0 0 0", out_valid, D, Bout);
        end
`ifdef KS_SUB_OVERFLOW_EN
        total++;
        if (V !== 1'b0) begin
            bad++;
            $display("FAIL reset_v: V=%b, required 0", V);
        end
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Operands captured at the first edge, result visible after the second
    task automatic test_latency();
        out_ready = 1'b1;
        A = 32'h0;
        B = 32'h0;
        Bin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL latency_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: out_valid=%b after 1st edge, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || D !== 32'h0 || Bout !== 1'b0) begin
            bad++;
            $display("FAIL latency_result: out_valid=%b D=%h Bout=%b after 2nd edge, required 1 00000000 0",
                     out_valid, D, Bout);
        end
        drain();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        v;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[8];
        int   n;
        logic seen;
        tbl = '{
            '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0},
            '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0},
            '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0},
            '{32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1},
            '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0},
            '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1}
        };
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(tbl[k].a, tbl[k].b, tbl[k].bin);
            in_valid = 1'b0;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 5) begin
                @(negedge clk);
                seen = out_valid;
                if (seen) begin
                    total++;
                    if (D !== tbl[k].d || Bout !== tbl[k].bout) begin
                        bad++;
                        $display("FAIL directed_%0d: D=%h Bout=%b, required D=%h Bout=%b",
                                 k, D, Bout, tbl[k].d, tbl[k].bout);
                    end
`ifdef KS_SUB_OVERFLOW_EN
                    total++;
                    if (V !== tbl[k].v) begin
                        bad++;
                        $display("FAIL directed_v_%0d: V=%b, required %b", k, V, tbl[k].v);
                    end
`endif
                end
                @(posedge clk);
                #1;
                n++;
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL directed_timeout_%0d: out_valid=0, required 1 within 5 cycles", k);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[4];
        logic [31:0] vb[4];
        exp_t        first;
        va = '{32'h1234_5678, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0000_0010};
        vb = '{32'h0000_FFFF, 32'h0000_0001, 32'hDEAD_BEF0, 32'h0000_0020};
        first = model(va[0], vb[0], 1'b0);
        out_ready = 1'b0;
        send(va[0], vb[0], 1'b0);
        send(va[1], vb[1], 1'b0);
        A = va[2];
        B = vb[2];
        Bin = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_full_%0d: in_ready=%b, required 0", c, in_ready);
            end
            total++;
            if (out_valid !== 1'b1 || D !== first.d || Bout !== first.bout) begin
                bad++;
                $display("FAIL b2b_hold_%0d: out_valid=%b D=%h Bout=%b, required 1 %h %b",
                         c, out_valid, D, Bout, first.d, first.bout);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(va[2], vb[2], 1'b0);
        send(va[3], vb[3], 1'b1);
        drain();
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(32'hAAAA_0000, 32'h0000_0001, 1'b0);
        send(32'h5555_5555, 32'h1111_1111, 1'b1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || D !== 32'h0 || Bout !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_async: out_valid=%b D=%h Bout=%b in_ready=%b, required 0 0 0 1",
                     out_valid, D, Bout, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_stale_%0d: out_valid=%b D=%h, required out_valid 0", c, out_valid, D);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d results never delivered, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
